ram_sp_ctrl: RTL and testbench

//  Parametrised single-port synchronous data/program RAM with a valid/ready request

---
 rtl/ram_pkg.sv | 25 ++
 rtl/ram_rd_pipe.sv | 54 +++++
 rtl/ram_sp_ctrl.sv | 145 ++++++++++++++
 tb/tb_ram_sp_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Brief    : Shared types and parameter helpers for the single-port RAM block.
// Revision : 1.0
// ============================================================================
package ram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int c_BYTE_W = 8;

    function automatic int be_width(input int data_w);
        return data_w / c_BYTE_W;
    endfunction

    function automatic bit rd_lat_ok(input int rd_lat);
        return (rd_lat == 1) || (rd_lat == 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ram_rd_pipe
// Brief    : RD_LAT-deep valid/err/data shift register for read responses.
// Revision : 1.0
// ============================================================================
module ram_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_err,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic              o_err,
    output logic [DATA_W-1:0] o_data
);

    logic [RD_LAT-1:0] r_valid;
    logic [RD_LAT-1:0] r_err;
    logic [DATA_W-1:0] r_data [RD_LAT];

    // Data/err stages only load alongside a valid, so the output holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_err   <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                r_data[s] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            if (i_valid) begin
                r_err[0]  <= i_err;
                r_data[0] <= i_data;
            end
            for (int s = 1; s < RD_LAT; s++) begin
                r_valid[s] <= r_valid[s-1];
                if (r_valid[s-1]) begin
                    r_err[s]  <= r_err[s-1];
                    r_data[s] <= r_data[s-1];
                end
            end
        end
    end

    assign o_valid = r_valid[RD_LAT-1];
    assign o_err   = r_err[RD_LAT-1];
    assign o_data  = r_data[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/ram_sp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_ctrl
// Brief    : Single-port RAM with valid/ready requests, byte enables,
//            1- or 2-cycle read latency and a post-reset clear sequencer.
// Revision : 1.0
// ============================================================================
module ram_sp_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 32768,
    parameter int ADDR_W     = 15,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_busy
);

    localparam int              c_BE_W      = be_width(DATA_W);
    localparam int              c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] c_DEPTH     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(DEPTH - 1);
    localparam state_t          c_RST_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;

    if (!rd_lat_ok(RD_LAT) || ((DATA_W % 8) != 0)) begin : g_param_err
        $error("ram_sp_ctrl: RD_LAT must be 1 or 2 and DATA_W a multiple of 8");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_cnt_nxt;
    logic                r_req_ready;
    logic                r_init_busy;
    logic                w_ready_nxt;
    logic                w_busy_nxt;

    logic                w_accept;
    logic                w_in_range;
    logic                w_rd;
    logic                w_rd_err;
    logic [DATA_W-1:0]   w_rd_data;

    logic                w_mem_we;
    logic [c_BE_W-1:0]   w_mem_be;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    // Handshake outputs are registered so they read 0 while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_RST_STATE;
            r_clr_cnt   <= '0;
            r_req_ready <= 1'b0;
            r_init_busy <= (INIT_CLEAR != 0);
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_req_ready <= w_ready_nxt;
            r_init_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_cnt == c_LAST) begin
                    w_state_nxt   = ST_RUN;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_ready_nxt = (w_state_nxt == ST_RUN);
        w_busy_nxt  = (w_state_nxt == ST_CLEAR);
        if (r_state == ST_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_be    = '1;
            w_mem_addr  = r_clr_cnt;
            w_mem_wdata = '0;
        end else begin
            w_mem_we    = w_accept & req_we & w_in_range;
            w_mem_be    = req_be;
            w_mem_addr  = req_addr;
            w_mem_wdata = req_wdata;
        end
    end

    assign w_accept   = req_valid & r_req_ready;
    assign w_in_range = ({1'b0, req_addr} < c_DEPTH);
    assign w_rd       = w_accept & ~req_we;
    assign w_rd_err   = ~w_in_range;
    assign w_rd_data  = w_in_range ? r_mem[req_addr[c_IDX_W-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_BE_W; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_addr[c_IDX_W-1:0]][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_rd),
        .i_err   (w_rd_err),
        .i_data  (w_rd_data),
        .o_valid (rsp_valid),
        .o_err   (rsp_err),
        .o_data  (rsp_rdata)
    );

    assign req_ready = r_req_ready;
    assign init_busy = r_init_busy;

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_sp_ctrl
// Brief    : Scoreboard bench for ram_sp_ctrl: 8-bit/32-deep/lat-1/clear and
//            32-bit/24-deep/lat-2/no-clear instances.
// Revision : 1.0
// ============================================================================
module tb_ram_sp_ctrl;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Instance A: DATA_W=8, DEPTH=32, RD_LAT=1, INIT_CLEAR=1
    logic        rst_a = 1'b1, va = 1'b0, wea = 1'b0;
    logic [4:0]  addra = '0;
    logic [7:0]  wda = '0;
    logic [0:0]  bea = '0;
    logic        ra, rva, rea, ba;
    logic [7:0]  rda;
    // Instance B: DATA_W=32, DEPTH=24, RD_LAT=2, INIT_CLEAR=0
    logic        rst_b = 1'b1, vb = 1'b0, web = 1'b0;
    logic [4:0]  addrb = '0;
    logic [31:0] wdb = '0;
    logic [3:0]  beb = '0;
    logic        rb, rvb, reb, bb;
    logic [31:0] rdb;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [7:0]  ma [32];
    logic [31:0] mb [24];

    ram_sp_ctrl #(.DATA_W(8), .DEPTH(32), .ADDR_W(5), .RD_LAT(1), .INIT_CLEAR(1)) u_dut_a (
        .clk(clk), .rst(rst_a), .req_valid(va), .req_ready(ra), .req_we(wea),
        .req_addr(addra), .req_wdata(wda), .req_be(bea), .rsp_valid(rva),
        .rsp_rdata(rda), .rsp_err(rea), .init_busy(ba)
    );

    ram_sp_ctrl #(.DATA_W(32), .DEPTH(24), .ADDR_W(5), .RD_LAT(2), .INIT_CLEAR(0)) u_dut_b (
        .clk(clk), .rst(rst_b), .req_valid(vb), .req_ready(rb), .req_we(web),
        .req_addr(addrb), .req_wdata(wdb), .req_be(beb), .rsp_valid(rvb),
        .rsp_rdata(rdb), .rsp_err(reb), .init_busy(bb)
    );

    always @(negedge clk) begin
        if (rva) begin
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL rsp_a_unexpected: got data=%0h err=%0b at cyc=%0d, want no response", rda, rea, cyc);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if (rda !== e.data[7:0] || rea !== e.err || cyc != e.due) begin
                    bad++;
                    $display("FAIL rsp_a: got data=%0h err=%0b cyc=%0d, want data=%0h err=%0b cyc=%0d",
                             rda, rea, cyc, e.data[7:0], e.err, e.due);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rvb) begin
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL rsp_b_unexpected: got data=%0h err=%0b at cyc=%0d, want no response", rdb, reb, cyc);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if (rdb !== e.data || reb !== e.err || cyc != e.due) begin
                    bad++;
                    $display("FAIL rsp_b: got data=%0h err=%0b cyc=%0d, want data=%0h err=%0b cyc=%0d",
                             rdb, reb, cyc, e.data, e.err, e.due);
                end
            end
        end
    end

    // Drives one request for one cycle; call at a negedge.
    task automatic op_a(input logic we, input logic [4:0] addr, input logic [7:0] d);
        va = 1'b1; wea = we; addra = addr; wda = d; bea = 1'b1;
        if (we) ma[addr] = d;
        else    qa.push_back('{cyc + 1, 1'b0, {24'h0, ma[addr]}});
        @(negedge clk);
        va = 1'b0;
    endtask

    task automatic op_b(input logic we, input logic [4:0] addr, input logic [31:0] d, input logic [3:0] be);
        vb = 1'b1; web = we; addrb = addr; wdb = d; beb = be;
        if (we) begin
            if (addr < 5'd24)
                for (int b = 0; b < 4; b++)
                    if (be[b]) mb[addr][b*8 +: 8] = d[b*8 +: 8];
        end else if (addr < 5'd24) begin
            qb.push_back('{cyc + 2, 1'b0, mb[addr]});
        end else begin
            qb.push_back('{cyc + 2, 1'b1, 32'h0});
        end
        @(negedge clk);
        vb = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d pending responses, want 0/0", qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    // Counts negedges from reset release until req_ready rises on A.
    task automatic count_clear_a(output int k, output int early);
        k = 0;
        early = 0;
        while (ra !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
            if (ra !== 1'b1 && ba !== 1'b1) early++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if (rva !== 1'b0)   begin bad++; $display("FAIL rst_a_valid: got %0b want 0", rva); end
        total++; if (rda !== 8'h00)  begin bad++; $display("FAIL rst_a_rdata: got %0h want 0", rda); end
        total++; if (rea !== 1'b0)   begin bad++; $display("FAIL rst_a_err: got %0b want 0", rea); end
        total++; if (ra !== 1'b0)    begin bad++; $display("FAIL rst_a_ready: got %0b want 0", ra); end
        total++; if (ba !== 1'b1)    begin bad++; $display("FAIL rst_a_busy: got %0b want 1", ba); end
        total++; if (rvb !== 1'b0)   begin bad++; $display("FAIL rst_b_valid: got %0b want 0", rvb); end
        total++; if (rdb !== 32'h0)  begin bad++; $display("FAIL rst_b_rdata: got %0h want 0", rdb); end
        total++; if (rb !== 1'b0)    begin bad++; $display("FAIL rst_b_ready: got %0b want 0", rb); end
        total++; if (bb !== 1'b0)    begin bad++; $display("FAIL rst_b_busy: got %0b want 0", bb); end
    endtask

    task automatic test_clear;
        int k, early;
        rst_a = 1'b0;
        rst_b = 1'b0;
        count_clear_a(k, early);
        total++; if (k != 32)     begin bad++; $display("FAIL clear_len: got %0d cycles want 32", k); end
        total++; if (early != 0)  begin bad++; $display("FAIL clear_busy: got %0d early drops want 0", early); end
        total++; if (ba !== 1'b0) begin bad++; $display("FAIL clear_done_busy: got %0b want 0", ba); end
        for (int i = 0; i < 32; i++) op_a(1'b0, 5'(i), 8'h00);
        drain();
    endtask

    task automatic test_byte_enable;
        op_b(1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
        op_b(1'b1, 5'd5, 32'h00001100, 4'b0010);
        op_b(1'b1, 5'd5, 32'hFFFFFFFF, 4'b0000);
        op_b(1'b0, 5'd5, 32'h0, 4'h0);
        drain();
        total++; if (rdb !== 32'hDEAD11EF) begin bad++; $display("FAIL be_merge: got %0h want deadbeef->dead11ef", rdb); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) op_a(1'b1, 5'(i), 8'(8'h10 + i));
        for (int i = 0; i < 4; i++) op_b(1'b1, 5'(i), 32'hA0000000 + i, 4'hF);
        for (int i = 0; i < 4; i++) op_a(1'b0, 5'(i), 8'h00);
        drain();
        for (int i = 0; i < 4; i++) op_b(1'b0, 5'(i), 32'h0, 4'h0);
        drain();
    endtask

    task automatic test_ordering;
        op_a(1'b1, 5'd7, 8'h11);
        op_a(1'b0, 5'd7, 8'h00);
        op_a(1'b1, 5'd7, 8'h22);
        op_a(1'b0, 5'd7, 8'h00);
        drain();
        total++; if (rda !== 8'h22) begin bad++; $display("FAIL order_reread: got %0h want 22", rda); end
    endtask

    task automatic test_out_of_range;
        for (int i = 0; i < 24; i++) op_b(1'b1, 5'(i), {8'(i), 8'hC3, 8'(~i), 8'h3C}, 4'hF);
        op_b(1'b1, 5'd30, 32'hFFFFFFFF, 4'hF);
        op_b(1'b1, 5'd24, 32'h12345678, 4'hF);
        op_b(1'b0, 5'd30, 32'h0, 4'h0);
        op_b(1'b0, 5'd24, 32'h0, 4'h0);
        for (int i = 0; i < 24; i++) op_b(1'b0, 5'(i), 32'h0, 4'h0);
        drain();
    endtask

    task automatic test_reset_mid;
        int k, early, leaks;
        // A: read in flight when reset arrives
        op_a(1'b1, 5'd3, 8'h5A);
        va = 1'b1; wea = 1'b0; addra = 5'd3;
        @(posedge clk); #1;
        va = 1'b0;
        total++; if (rva !== 1'b1 || rda !== 8'h5A) begin bad++; $display("FAIL inflight_a: got v=%0b d=%0h want v=1 d=5a", rva, rda); end
        rst_a = 1'b1;
        #1;
        total++; if (rva !== 1'b0) begin bad++; $display("FAIL rst_drop_a: got %0b want 0", rva); end
        @(negedge clk);
        rst_a = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (ba !== 1'b1 || ra !== 1'b0) begin bad++; $display("FAIL mid_clear: got busy=%0b ready=%0b want 1/0", ba, ra); end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        count_clear_a(k, early);
        total++; if (k != 32)    begin bad++; $display("FAIL restart_len: got %0d cycles want 32", k); end
        total++; if (early != 0) begin bad++; $display("FAIL restart_busy: got %0d early drops want 0", early); end
        for (int i = 0; i < 32; i++) ma[i] = 8'h00;
        for (int i = 0; i < 32; i++) op_a(1'b0, 5'(i), 8'h00);
        drain();
        // B: read in flight, INIT_CLEAR=0 keeps contents
        vb = 1'b1; web = 1'b0; addrb = 5'd2;
        @(posedge clk); #1;
        vb = 1'b0;
        rst_b = 1'b1;
        leaks = 0;
        repeat (3) begin
            @(negedge clk);
            if (rvb !== 1'b0) leaks++;
        end
        total++; if (leaks != 0) begin bad++; $display("FAIL rst_drop_b: got %0d valid cycles want 0", leaks); end
        rst_b = 1'b0;
        @(negedge clk);
        total++; if (rb !== 1'b1 || bb !== 1'b0) begin bad++; $display("FAIL b_run: got ready=%0b busy=%0b want 1/0", rb, bb); end
        for (int i = 0; i < 24; i++) op_b(1'b0, 5'(i), 32'h0, 4'h0);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) ma[i] = 8'h00;
        test_reset();
        test_clear();
        test_byte_enable();
        test_back_to_back();
        test_ordering();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
